// File: rtl/mf_trigger_pkg.sv
// Shared types for the matched-filter trigger: FSM states, trigger record layout
// and the drop counter width.
package mf_trigger_pkg;

   localparam int MF_INBITS    = 16;
   localparam int MF_TIME_BITS = 32;
   localparam int DROP_BITS    = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_SEARCH  = 2'd2,
      ST_HOLDOFF = 2'd3
   } mf_state_e;

   // ts is {cycle, lane} of the peak sample
   typedef struct packed {
      logic [MF_TIME_BITS:0] ts;
      logic [MF_INBITS-1:0]  peak;
   } mf_record_t;

   localparam int REC_BITS = $bits(mf_record_t);

endpackage

// File: rtl/mf_trigger_outreg.sv
// One-entry valid/ready holding register for trigger records, counting records
// that arrive while an unaccepted one is still held.
module mf_trigger_outreg
   import mf_trigger_pkg::*;
#(
   parameter int REC_W = REC_BITS
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 push_i,
   input  logic [REC_W-1:0]     rec_i,
   input  logic                 ready_i,
   output logic                 valid_o,
   output logic [REC_W-1:0]     rec_o,
   output logic [DROP_BITS-1:0] drop_count_o
);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_o      <= 1'b0;
         rec_o        <= '0;
         drop_count_o <= '0;
      end else begin
         if (push_i) begin
            // an acceptance on this edge frees the slot for the new record
            if (valid_o && !ready_i) begin
               if (drop_count_o != '1)
                  drop_count_o <= drop_count_o + DROP_BITS'(1);
            end else begin
               valid_o <= 1'b1;
               rec_o   <= rec_i;
            end
         end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/matched_filter_trigger.sv
// Threshold-excursion peak finder on the two-lane matched filter output; emits one
// {timestamp, peak} record per excursion.
//
// state   | meaning
// IDLE    | disabled; waits for enable
// ARMED   | looking for the first over-threshold sample
// SEARCH  | tracking the peak until a sample falls to/below threshold or the cap
// HOLDOFF | ignoring input for holdoff_i further cycles after a record
module matched_filter_trigger
   import mf_trigger_pkg::*;
#(
   parameter int INBITS       = MF_INBITS,
   parameter int TIME_BITS    = MF_TIME_BITS,
   parameter int HOLDOFF_BITS = 8,
   parameter int MAX_SEARCH   = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [INBITS-1:0]       in0_i,
   input  logic [INBITS-1:0]       in1_i,
   input  logic                    enable_i,
   input  logic [INBITS-1:0]       threshold_i,
   input  logic [HOLDOFF_BITS-1:0] holdoff_i,
   output logic                    trig_valid_o,
   input  logic                    trig_ready_i,
   output logic [TIME_BITS:0]      trig_time_o,
   output logic [INBITS-1:0]       trig_peak_o,
   output logic [7:0]              drop_count_o
);

   localparam int SRCH_BITS = $clog2(MAX_SEARCH + 1);
   localparam logic [SRCH_BITS-1:0] SRCH_LOAD = SRCH_BITS'(MAX_SEARCH - 1);

   logic signed [INBITS-1:0] in0_q, in1_q;
   logic signed [INBITS-1:0] peak_q, peak_d;
   logic [TIME_BITS-1:0]     cyc_q, ts_q;
   logic [TIME_BITS-1:0]     pt_q, pt_d;
   logic                     lane_q, lane_d;
   logic                     over0, over1;
   logic                     end_s, push_d, push_q;
   mf_state_e                state_q, state_d;
   logic [SRCH_BITS-1:0]     srch_q, srch_d;
   logic [HOLDOFF_BITS-1:0]  hold_q, hold_d;
   mf_record_t               rec_q, out_rec;
   logic [REC_BITS-1:0]      out_vec;

   // input pair and the cycle stamp it was sampled under travel together
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         in0_q <= '0;
         in1_q <= '0;
         ts_q  <= '0;
         cyc_q <= '0;
      end else begin
         in0_q <= in0_i;
         in1_q <= in1_i;
         ts_q  <= cyc_q;
         if (enable_i)
            cyc_q <= cyc_q + TIME_BITS'(1);
      end
   end

   assign over0 = in0_q > $signed(threshold_i);
   assign over1 = in1_q > $signed(threshold_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         peak_q  <= '0;
         lane_q  <= 1'b0;
         pt_q    <= '0;
         srch_q  <= '0;
         hold_q  <= '0;
         push_q  <= 1'b0;
         rec_q   <= '0;
      end else begin
         state_q <= state_d;
         peak_q  <= peak_d;
         lane_q  <= lane_d;
         pt_q    <= pt_d;
         srch_q  <= srch_d;
         hold_q  <= hold_d;
         push_q  <= push_d;
         if (push_d) begin
            rec_q.ts   <= {pt_d, lane_d};
            rec_q.peak <= peak_d;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      peak_d  = peak_q;
      lane_d  = lane_q;
      pt_d    = pt_q;
      srch_d  = srch_q;
      hold_d  = hold_q;
      end_s   = 1'b0;

      case (state_q)
         ST_IDLE: state_d = ST_ARMED;

         ST_ARMED: begin
            if (over0) begin
               peak_d = in0_q;
               lane_d = 1'b0;
               pt_d   = ts_q;
               if (over1) begin
                  if (in1_q > in0_q) begin
                     peak_d = in1_q;
                     lane_d = 1'b1;
                  end
                  state_d = ST_SEARCH;
                  srch_d  = SRCH_LOAD;
               end else begin
                  end_s = 1'b1;
               end
            end else if (over1) begin
               peak_d  = in1_q;
               lane_d  = 1'b1;
               pt_d    = ts_q;
               state_d = ST_SEARCH;
               srch_d  = SRCH_LOAD;
            end
         end

         ST_SEARCH: begin
            // lane 1 is only considered while lane 0 keeps the excursion alive
            if (!over0) begin
               end_s = 1'b1;
            end else begin
               if (in0_q > peak_q) begin
                  peak_d = in0_q;
                  lane_d = 1'b0;
                  pt_d   = ts_q;
               end
               if (!over1) begin
                  end_s = 1'b1;
               end else begin
                  if (in1_q > peak_d) begin
                     peak_d = in1_q;
                     lane_d = 1'b1;
                     pt_d   = ts_q;
                  end
                  if (srch_q == '0)
                     end_s = 1'b1;
                  else
                     srch_d = srch_q - SRCH_BITS'(1);
               end
            end
         end

         ST_HOLDOFF: begin
            if (hold_q == '0)
               state_d = ST_ARMED;
            else
               hold_d = hold_q - HOLDOFF_BITS'(1);
         end

         default: state_d = ST_IDLE;
      endcase

      if (end_s) begin
         state_d = ST_HOLDOFF;
         hold_d  = holdoff_i;
      end

      // disabling mid-search discards the excursion without a record
      push_d = end_s & enable_i;
      if (!enable_i)
         state_d = ST_IDLE;
   end

   mf_trigger_outreg #(
      .REC_W (REC_BITS)
   ) u_outreg (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .push_i       (push_q),
      .rec_i        (rec_q),
      .ready_i      (trig_ready_i),
      .valid_o      (trig_valid_o),
      .rec_o        (out_vec),
      .drop_count_o (drop_count_o)
   );

   assign out_rec     = out_vec;
   assign trig_time_o = out_rec.ts;
   assign trig_peak_o = out_rec.peak;

endmodule

// File: tb/tb_matched_filter_trigger.sv
// Directed bench for matched_filter_trigger: excursion-level reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_matched_filter_trigger;

   localparam int INBITS       = 16;
   localparam int TIME_BITS    = 32;
   localparam int HOLDOFF_BITS = 8;
   localparam int MAX_SEARCH   = 32;

   logic        clk_i        = 1'b0;
   logic        rst_ni       = 1'b0;
   logic        enable_i     = 1'b0;
   logic        trig_ready_i = 1'b1;
   logic [15:0] in0_i        = '0;
   logic [15:0] in1_i        = '0;
   logic [15:0] threshold_i  = 16'd100;
   logic [7:0]  holdoff_i    = '0;
   logic        trig_valid_o;
   logic [32:0] trig_time_o;
   logic [15:0] trig_peak_o;
   logic [7:0]  drop_count_o;

   int vectors     = 0;
   int miscompares = 0;

   matched_filter_trigger #(
      .INBITS       (INBITS),
      .TIME_BITS    (TIME_BITS),
      .HOLDOFF_BITS (HOLDOFF_BITS),
      .MAX_SEARCH   (MAX_SEARCH)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .in0_i        (in0_i),
      .in1_i        (in1_i),
      .enable_i     (enable_i),
      .threshold_i  (threshold_i),
      .holdoff_i    (holdoff_i),
      .trig_valid_o (trig_valid_o),
      .trig_ready_i (trig_ready_i),
      .trig_time_o  (trig_time_o),
      .trig_peak_o  (trig_peak_o),
      .drop_count_o (drop_count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string nm, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // phase: 0 idle, 1 armed, 2 searching, 3 holdoff
   bit          m_valid;
   logic [32:0] m_time;
   int          m_peak, m_drop;
   bit          p_push;
   logic [32:0] p_time;
   int          p_peak;
   int          phase, pk, pl, scnt, hcnt, s0, s1, thr, v;
   logic [31:0] pt, sts, m_cnt;
   bit          was, done;

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         m_valid = 0; m_time = '0; m_peak = 0; m_drop = 0;
         p_push = 0; p_time = '0; p_peak = 0;
         phase = 0; pk = 0; pl = 0; pt = '0; scnt = 0; hcnt = 0;
         s0 = 0; s1 = 0; sts = '0; m_cnt = '0;
      end else begin
         if (p_push) begin
            if (m_valid && !trig_ready_i) begin
               if (m_drop < 255) m_drop++;
            end else begin
               m_valid = 1; m_time = p_time; m_peak = p_peak;
            end
         end else if (m_valid && trig_ready_i) begin
            m_valid = 0;
         end
         p_push = 0;
         thr = int'($signed(threshold_i));
         if (!enable_i) phase = 0;
         else if (phase == 0) phase = 1;
         else if (phase == 3) begin
            if (hcnt == 0) phase = 1; else hcnt--;
         end else begin
            was  = (phase == 2);
            done = 0;
            for (int l = 0; l < 2 && !done; l++) begin
               v = (l == 1) ? s1 : s0;
               if (v > thr) begin
                  if (phase == 1) begin
                     phase = 2; pk = v; pl = l; pt = sts; scnt = 0;
                  end else if (v > pk) begin
                     pk = v; pl = l; pt = sts;
                  end
               end else if (phase == 2) begin
                  done = 1;
               end
            end
            if (phase == 2 && was && !done) begin
               scnt++;
               if (scnt == MAX_SEARCH) done = 1;
            end
            if (done) begin
               p_push = 1; p_peak = pk; p_time = {pt, pl[0]};
               phase = 3; hcnt = int'(holdoff_i);
            end
         end
         s0 = int'($signed(in0_i));
         s1 = int'($signed(in1_i));
         sts = m_cnt;
         if (enable_i) m_cnt++;
      end
   end

   // per-cycle compare
   always @(negedge clk_i) begin
      if (rst_ni) begin
         chk("valid", longint'(trig_valid_o), longint'(m_valid));
         if (m_valid) begin
            chk("time", longint'(trig_time_o), longint'(m_time));
            chk("peak", longint'($signed(trig_peak_o)), longint'(m_peak));
         end
         chk("drop", longint'(drop_count_o), longint'(m_drop));
      end
   end

   // accepted records and the cycle stamp the DUT counter should hold
   int          seen_peak[$];
   logic [31:0] en_edges;
   always @(posedge clk_i) begin
      if (rst_ni && trig_valid_o && trig_ready_i)
         seen_peak.push_back(int'($signed(trig_peak_o)));
   end
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) en_edges <= '0;
      else if (enable_i) en_edges <= en_edges + 32'd1;
   end

   task automatic pair(input int a, input int b);
      @(negedge clk_i);
      in0_i = 16'(a);
      in1_i = 16'(b);
   endtask

   task automatic idle(input int n);
      repeat (n) pair(0, 0);
   endtask

   task automatic wait_valid(input string nm, input int bound);
      int n = 0;
      while (!trig_valid_o && n < bound) begin
         @(negedge clk_i);
         n++;
      end
      chk(nm, longint'(trig_valid_o), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [31:0] ts;
      int base;

      repeat (3) @(negedge clk_i);
      chk("rst_valid", longint'(trig_valid_o), 0);
      chk("rst_time", longint'(trig_time_o), 0);
      chk("rst_peak", longint'(trig_peak_o), 0);
      chk("rst_drop", longint'(drop_count_o), 0);
      #2 rst_ni = 1'b1;
      @(negedge clk_i);
      enable_i = 1'b1;
      idle(6);

      // one excursion starting in lane 1, peak in lane 0 of the second pair
      pair(50, 120);
      pair(150, 90);
      ts = en_edges;
      pair(0, 0);
      chk("t1_lat1", longint'(trig_valid_o), 0);
      pair(0, 0);
      chk("t1_lat2", longint'(trig_valid_o), 0);
      pair(0, 0);
      chk("t1_valid", longint'(trig_valid_o), 1);
      chk("t1_peak", longint'($signed(trig_peak_o)), 150);
      chk("t1_time", longint'(trig_time_o), longint'({ts, 1'b0}));

      // tie keeps the earlier sample
      idle(4);
      pair(50, 200);
      pair(300, 300);
      ts = en_edges;
      pair(10, 10);
      wait_valid("t2_wait", 8);
      chk("t2_peak", longint'($signed(trig_peak_o)), 300);
      chk("t2_time", longint'(trig_time_o), longint'({ts, 1'b0}));

      // holdoff spacing with alternating over/under pairs
      idle(4);
      threshold_i = 16'd0;
      holdoff_i   = 8'd5;
      base = seen_peak.size();
      for (int k = 0; k < 24; k++) begin
         if (k % 2 == 0) pair(k + 1, k + 1);
         else            pair(-5, -5);
      end
      idle(6);
      chk("t3_count", longint'(seen_peak.size() - base), 3);
      if (seen_peak.size() >= base + 3) begin
         chk("t3_peak0", longint'(seen_peak[base]), 1);
         chk("t3_peak1", longint'(seen_peak[base+1]), 9);
         chk("t3_peak2", longint'(seen_peak[base+2]), 17);
      end

      // back-pressure: first record held, later ones dropped
      threshold_i = 16'd100;
      holdoff_i   = 8'd0;
      idle(6);
      trig_ready_i = 1'b0;
      pair(150, 50); idle(3);
      pair(160, 50); idle(3);
      pair(170, 50); idle(5);
      chk("t4_held_valid", longint'(trig_valid_o), 1);
      chk("t4_held_peak", longint'($signed(trig_peak_o)), 150);
      chk("t4_drop", longint'(drop_count_o), 2);
      trig_ready_i = 1'b1;
      @(negedge clk_i);
      chk("t4_after_xfer", longint'(trig_valid_o), 0);

      // long excursion forced out after the search cap
      holdoff_i = 8'd3;
      idle(4);
      base = seen_peak.size();
      for (int i = 0; i < 40; i++) pair(200 + i, 200);
      idle(8);
      chk("t5_count", longint'(seen_peak.size() - base), 2);
      if (seen_peak.size() >= base + 2) begin
         chk("t5_forced_peak", longint'(seen_peak[base]), 232);
         chk("t5_second_peak", longint'(seen_peak[base+1]), 239);
      end

      // enable dropped mid-search: no record
      holdoff_i = 8'd0;
      idle(6);
      base = seen_peak.size();
      pair(150, 150);
      pair(160, 160);
      pair(170, 170);
      enable_i = 1'b0;
      pair(0, 0);
      enable_i = 1'b1;
      idle(8);
      chk("t6_abort_no_rec", longint'(seen_peak.size() - base), 0);

      // reset pulsed mid-holdoff with a record pending
      holdoff_i    = 8'd10;
      trig_ready_i = 1'b0;
      pair(150, 50);
      pair(0, 0);
      wait_valid("t6_wait", 8);
      @(negedge clk_i);
      #2 rst_ni = 1'b0;
      #1;
      chk("t6_rst_valid", longint'(trig_valid_o), 0);
      chk("t6_rst_time", longint'(trig_time_o), 0);
      chk("t6_rst_peak", longint'(trig_peak_o), 0);
      chk("t6_rst_drop", longint'(drop_count_o), 0);
      repeat (2) @(negedge clk_i);
      #2 rst_ni = 1'b1;
      trig_ready_i = 1'b1;
      idle(6);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
